// File: rtl/seq_divider_rv_pkg.sv
// Shared definitions for the iterative RISC-V M-extension divider.
// Holds the op encodings, the FSM state enum and small op-decode helpers.
package seq_divider_rv_pkg;

    localparam int unsigned DIV_OP_W = 2;

    // Operation encodings as presented on the op port
    typedef enum logic [DIV_OP_W-1:0] {
        DIV_OP_DIV  = 2'd0,
        DIV_OP_DIVU = 2'd1,
        DIV_OP_REM  = 2'd2,
        DIV_OP_REMU = 2'd3
    } div_op_e;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // DIV and REM are the signed variants (bit 0 clear)
    function automatic logic op_is_signed(input div_op_e op);
        return ~op[0];
    endfunction

    // REM and REMU return the remainder (bit 1 set)
    function automatic logic op_is_rem(input div_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/seq_divider_rv_if.sv
// Request/response bundle between the execute stage and the divider.
//   master: issues in_valid/op/dividend/divisor, accepts results with out_ready
//   slave : the divider; returns in_ready, out_valid, result and status flags
interface seq_divider_rv_if #(
    parameter int unsigned WIDTH = 32
);
    import seq_divider_rv_pkg::*;

    logic             in_valid;
    logic             in_ready;
    div_op_e          op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output in_valid, op, dividend, divisor, out_ready,
        input  in_ready, out_valid, result, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, op, dividend, divisor, out_ready,
        output in_ready, out_valid, result, div_by_zero, overflow
    );

endinterface

// File: rtl/seq_divider_rv_div_step.sv
// One combinational restoring-division iteration.
//   acc_in      : partial remainder (WIDTH+1 bits)
//   q_in        : remaining dividend bits / quotient being built
//   divisor     : unsigned divisor magnitude
//   acc_next_c  : partial remainder after this step
//   q_next_c    : quotient shifted with the new bit in the LSB
module seq_divider_rv_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   acc_next_c,
    output logic [WIDTH-1:0] q_next_c
);

    // One extra bit of headroom so the shifted accumulator never loses its MSB
    logic [WIDTH+1:0] shifted_c;
    logic [WIDTH+1:0] dvsr_ext_c;

    always_comb begin
        shifted_c  = {acc_in, q_in[WIDTH-1]};
        dvsr_ext_c = {2'b00, divisor};
        if (shifted_c >= dvsr_ext_c) begin
            acc_next_c = (WIDTH+1)'(shifted_c - dvsr_ext_c);
            q_next_c   = {q_in[WIDTH-2:0], 1'b1};
        end else begin
            acc_next_c = (WIDTH+1)'(shifted_c);
            q_next_c   = {q_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider_rv.sv
// Iterative restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// One quotient bit per cycle on magnitudes, sign fix-up in a final cycle.
// Divide-by-zero and signed MIN/-1 are resolved at accept time.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of seq_divider_rv_if (request, response, flags)
module seq_divider_rv
    import seq_divider_rv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    seq_divider_rv_if.slave bus
);

    localparam int unsigned     CNT_W   = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};

    div_state_e       state_q, state_d;
    div_op_e          op_q, op_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH:0]   step_acc_c;
    logic [WIDTH-1:0] step_quo_c;

    // Single restoring iteration on the current accumulator/quotient
    seq_divider_rv_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .acc_in     (acc_q),
        .q_in       (quo_q),
        .divisor    (dvsr_q),
        .acc_next_c (step_acc_c),
        .q_next_c   (step_quo_c)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= DIV_OP_DIV;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            acc_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            acc_q       <= acc_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Decode of the incoming request
    logic             in_signed_c;
    logic             in_rem_c;
    logic [WIDTH-1:0] dividend_abs_c;
    logic [WIDTH-1:0] divisor_abs_c;
    logic [WIDTH-1:0] quo_fix_c;
    logic [WIDTH-1:0] rem_fix_c;

    always_comb begin
        in_signed_c    = op_is_signed(bus.op);
        in_rem_c       = op_is_rem(bus.op);
        // |MIN| fits as an unsigned WIDTH-bit value, so no extra bit is needed
        dividend_abs_c = (in_signed_c && bus.dividend[WIDTH-1])
                         ? (~bus.dividend + 1'b1) : bus.dividend;
        divisor_abs_c  = (in_signed_c && bus.divisor[WIDTH-1])
                         ? (~bus.divisor + 1'b1) : bus.divisor;
        quo_fix_c      = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        rem_fix_c      = neg_rem_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d      = bus.op;
                    neg_quo_d = in_signed_c && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    neg_rem_d = in_signed_c && bus.dividend[WIDTH-1];
                    if (bus.divisor == '0) begin
                        result_d = in_rem_c ? bus.dividend : ONES;
                        dbz_d    = 1'b1;
                        ovf_d    = 1'b0;
                        state_d  = DONE;
                    end else if (in_signed_c && (bus.dividend == MIN_VAL) &&
                                 (bus.divisor == ONES)) begin
                        result_d = in_rem_c ? '0 : MIN_VAL;
                        dbz_d    = 1'b0;
                        ovf_d    = 1'b1;
                        state_d  = DONE;
                    end else begin
                        acc_d   = '0;
                        quo_d   = dividend_abs_c;
                        dvsr_d  = divisor_abs_c;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b0;
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                acc_d = step_acc_c;
                quo_d = step_quo_c;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (cnt_q == LAST_IT) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                result_d = op_is_rem(op_q) ? rem_fix_c : quo_fix_c;
                state_d  = DONE;
            end

            DONE: begin
                if (bus.out_ready) begin
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs are registered copies of the next state
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider_rv.sv
// Scoreboard bench for seq_divider_rv at WIDTH=8.
module tb_seq_divider_rv;
    import seq_divider_rv_pkg::*;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         dbz;
        logic         ovf;
        int           lat;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];

    seq_divider_rv_if #(.WIDTH(W)) bus ();

    seq_divider_rv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from RISC-V semantics, using native signed arithmetic
    function automatic exp_t model(input div_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb_v;
        logic is_s;
        logic is_r;
        sa   = a;
        sb_v = b;
        is_s = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
        is_r = (op == DIV_OP_REM) || (op == DIV_OP_REMU);
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        e.lat = W + 2;
        if (b == 0) begin
            e.res = is_r ? a : 8'hFF;
            e.dbz = 1'b1;
            e.lat = 1;
        end else if (is_s && a == 8'h80 && b == 8'hFF) begin
            e.res = is_r ? 8'h00 : 8'h80;
            e.ovf = 1'b1;
            e.lat = 1;
        end else if (is_s) begin
            e.res = is_r ? W'(sa % sb_v) : W'(sa / sb_v);
        end else begin
            e.res = is_r ? (a % b) : (a / b);
        end
        return e;
    endfunction

    task automatic send(input div_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        check("in_ready_before_accept", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
        sb.push_back(model(op, a, b));
    endtask

    // Wait for the result, compare, optionally stall, then complete the handshake
    task automatic collect(input int hold);
        exp_t e;
        int   lat;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        check("latency", lat, e.lat);
        check("result", bus.result, e.res);
        check("div_by_zero", bus.div_by_zero, e.dbz);
        check("overflow", bus.overflow, e.ovf);
        for (int i = 0; i < hold; i++) begin
            if (i == 2) begin
                @(negedge clk);
                bus.in_valid = 1'b1;
                bus.op       = DIV_OP_DIVU;
                bus.dividend = 8'h11;
                bus.divisor  = 8'h03;
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_result", bus.result, e.res);
            check("hold_flags", {bus.div_by_zero, bus.overflow}, {e.dbz, e.ovf});
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("post_hs_out_valid", bus.out_valid, 0);
        check("post_hs_in_ready", bus.in_ready, 1);
        check("post_hs_flags", {bus.div_by_zero, bus.overflow}, 2'b00);
    endtask

    task automatic run(input div_op_e op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        send(op, a, b);
        collect(hold);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = DIV_OP_DIV;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_result", bus.result, 0);
        check("reset_flags", {bus.div_by_zero, bus.overflow}, 2'b00);
        reset = 1'b0;

        // Directed cases
        run(DIV_OP_DIV,  8'hF9, 8'h02, 0);
        run(DIV_OP_REM,  8'hF9, 8'h02, 0);
        run(DIV_OP_DIVU, 8'hF9, 8'h02, 0);
        run(DIV_OP_REMU, 8'hF9, 8'h02, 0);
        run(DIV_OP_DIVU, 8'h05, 8'h09, 0);
        run(DIV_OP_REMU, 8'h05, 8'h09, 0);
        run(DIV_OP_DIV,  8'h2A, 8'h00, 0);
        run(DIV_OP_REM,  8'h2A, 8'h00, 0);
        run(DIV_OP_DIV,  8'h80, 8'hFF, 0);
        run(DIV_OP_REM,  8'h80, 8'hFF, 0);
        run(DIV_OP_DIVU, 8'h80, 8'hFF, 0);

        // Backpressure with a stray in_valid pulse while DONE
        run(DIV_OP_DIV,  8'hF9, 8'h02, 5);
        run(DIV_OP_REM,  8'h2A, 8'h00, 5);

        // Reset while iterating
        send(DIV_OP_DIV, 8'h64, 8'h07);
        repeat (3) @(posedge clk);
        #1;
        check("calc_out_valid", bus.out_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_out_valid", bus.out_valid, 0);
        check("midreset_in_ready", bus.in_ready, 1);
        check("midreset_result", bus.result, 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("no_spurious_valid", bus.out_valid, 0);
        run(DIV_OP_DIV, 8'h64, 8'h07, 0);
        run(DIV_OP_REM, 8'h64, 8'h07, 0);

        // Random mix, biased toward the special divisors
        for (int n = 0; n < 40; n++) begin
            div_op_e     op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = div_op_e'($urandom_range(0, 3));
            a  = W'($urandom);
            b  = W'($urandom);
            case ($urandom_range(0, 5))
                0: b = 8'h00;
                1: begin a = 8'h80; b = 8'hFF; end
                2: b = 8'hFF;
                default: ;
            endcase
            run(op, a, b, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider_rv.md
Name: seq_divider_rv

Overview:
- Iterative restoring divider with RISC-V M-extension semantics: DIV, DIVU, REM and REMU.
- Parametrised width; signed and unsigned modes.
- Valid/ready handshakes on both input and output.
- Sits beside the integer ALU. The execute stage issues an op and stalls until the result handshake completes.
- Division by zero and signed overflow return architectural results; they never hang.

Parameters:
- WIDTH, 32, operand and result width in bits; must be ≥ 4.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- in_valid  input  1  request valid
- in_ready  output  1  divider idle and able to accept a request
- op  input  2  operation: 0=DIV, 1=DIVU, 2=REM, 3=REMU
- dividend  input  WIDTH  dividend, two's complement when op is signed
- divisor  input  WIDTH  divisor, two's complement when op is signed
- out_valid  output  1  result valid; held until accepted
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU)
- div_by_zero  output  1  flag qualified by out_valid: divisor was 0
- overflow  output  1  flag qualified by out_valid: signed MIN / -1 (DIV/REM only)

Behaviour:
- Reset (async) state and outputs:
  - state=IDLE, all internal registers 0.
  - in_ready=1, out_valid=0, result=0, div_by_zero=0, overflow=0.
- States: IDLE, CALC, FIX, DONE.
- in_ready = (state==IDLE). A request is accepted on a rising edge with in_valid && in_ready.
- On accept, latch op and the sign flags:
  - sign_q = signed op && (dividend[MSB] ^ divisor[MSB])
  - sign_r = signed op && dividend[MSB]
  - Latch |dividend| and |divisor|; absolute value only for signed ops. |MIN| is representable unsigned in WIDTH bits.
- Special cases are detected at accept and go directly IDLE->DONE (result valid 1 cycle after accept):
  - divisor==0: quotient = all ones; remainder = dividend (original value); div_by_zero=1.
  - Signed op, dividend==MIN, divisor==all ones: quotient = MIN; remainder = 0; overflow=1.
  - Unsigned ops never raise overflow.
- Normal path: IDLE->CALC.
  - CALC runs exactly WIDTH cycles, one quotient bit per cycle, MSB first.
  - Accumulator is WIDTH+1 bits. Each step: shift {acc, q} left by 1; if acc ≥ divisor, then acc -= divisor and q[0]=1.
  - Iteration counter is $clog2(WIDTH)+1 bits and saturates only at WIDTH.
- CALC->FIX after the WIDTH-th iteration.
  - FIX applies sign correction: negate q if sign_q; negate the remainder if sign_r.
  - FIX selects result by op.
- FIX->DONE.
  - Latency, accept edge to first out_valid cycle: WIDTH+2 edges normal, 1 edge special.
- DONE:
  - out_valid=1; result and flags stable until out_ready.
  - On a rising edge with out_ready=1: go to IDLE, out_valid=0, flags cleared.
  - in_ready stays 0 during DONE. No same-cycle accept of a new request; the next request can be accepted one cycle after the output handshake.
- in_valid is ignored outside IDLE. Inputs need not be held after accept.
- out_ready is ignored outside DONE.
- Reset mid-operation (any state) aborts immediately to the reset values; no spurious out_valid.
- Result sign rules (RISC-V): quotient truncates toward zero; remainder has the sign of the dividend.

Decomposition:
- Shared package (e.g. alu_pkg):
  - op encodings DIV_OP_DIV/DIVU/REM/REMU
  - state enum IDLE/CALC/FIX/DONE
- One natural sub-module: div_step, a combinational single restoring iteration.
  - Inputs: acc, q, divisor.
  - Outputs: next acc, next q.
  - Allows a future multi-bit-per-cycle variant by instancing it several times.
- Sign handling and the FSM stay in the top module.

Test Plan (WIDTH=8):
- DIV 0xF9 (-7) / 0x02 → result 0xFD (-3), flags 0. REM of the same operands → 0xFF (-1). Each out_valid arrives exactly 10 edges after accept.
- DIVU 0xF9 / 0x02 → 0x7C. REMU of the same operands → 0x01. DIVU 0x05 / 0x09 → 0x00. REMU 0x05 / 0x09 → 0x05.
- DIV 0x2A / 0x00 → result 0xFF, div_by_zero=1. REM 0x2A / 0x00 → 0x2A. Both valid 1 edge after accept.
- DIV 0x80 / 0xFF → result 0x80, overflow=1. REM 0x80 / 0xFF → 0x00, overflow=1. DIVU 0x80 / 0xFF → 0x00, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: result and flags stable, in_ready=0, and a pulse on in_valid ignored. Then raise out_ready for 1 cycle → IDLE, in_ready=1 on the next cycle.
- Assert reset during CALC of DIV 0x64 / 0x07. Required: out_valid=0 and in_ready=1 immediately. A fresh DIV 0x64 / 0x07 then gives 0x0E; REM gives 0x02.
